// File: rtl/mealy_mac_decoder.sv
// Receive-side decoder for the 4-state serial Mealy encoder: recovers one bit per legal
// symbol, flags illegal symbols and packs recovered bits LSB-first into WORD_W-bit words.
module mealy_mac_decoder #(
  parameter int unsigned WORD_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sym_valid_i,
  input  logic [1:0]        sym_in_i,
  input  logic              clear_err_i,
  output logic              bit_valid_o,
  output logic              bit_out_o,
  output logic              word_valid_o,
  output logic [WORD_W-1:0] word_out_o,
  output logic              err_pulse_o,
  output logic              err_flag_o
);

  localparam int unsigned CntW = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  typedef enum logic [1:0] {StS0, StS1, StS2, StS3} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WORD_W-1:0] shift_q, shift_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic              bit_valid_q, bit_valid_d;
  logic              bit_q, bit_d;
  logic              word_valid_q, word_valid_d;
  logic              err_pulse_q, err_pulse_d;
  logic              err_flag_q, err_flag_d;

  logic              legal;
  logic              dec_bit;
  state_e            dec_state;

  // Symbol decode for the current tracked state; anything not listed is illegal.
  always_comb begin
    legal     = 1'b0;
    dec_bit   = 1'b0;
    dec_state = StS0;
    unique case (state_q)
      StS0: begin
        case (sym_in_i)
          2'b00:   begin legal = 1'b1; dec_bit = 1'b1; dec_state = StS1; end
          2'b10:   begin legal = 1'b1; dec_bit = 1'b0; dec_state = StS1; end
          default: ;
        endcase
      end
      StS1: begin
        case (sym_in_i)
          2'b01:   begin legal = 1'b1; dec_bit = 1'b1; dec_state = StS2; end
          2'b00:   begin legal = 1'b1; dec_bit = 1'b0; dec_state = StS1; end
          default: ;
        endcase
      end
      StS2: begin
        case (sym_in_i)
          2'b10:   begin legal = 1'b1; dec_bit = 1'b1; dec_state = StS3; end
          2'b01:   begin legal = 1'b1; dec_bit = 1'b0; dec_state = StS1; end
          default: ;
        endcase
      end
      StS3: begin
        case (sym_in_i)
          2'b11:   begin legal = 1'b1; dec_bit = 1'b1; dec_state = StS2; end
          2'b00:   begin legal = 1'b1; dec_bit = 1'b0; dec_state = StS3; end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shift_d      = shift_q;
    word_d       = word_q;
    bit_valid_d  = 1'b0;
    bit_d        = bit_q;
    word_valid_d = 1'b0;
    err_pulse_d  = 1'b0;
    // A clear in the same cycle as an illegal symbol is overridden below.
    err_flag_d   = err_flag_q & ~clear_err_i;
    if (sym_valid_i) begin
      if (legal) begin
        state_d          = dec_state;
        bit_valid_d      = 1'b1;
        bit_d            = dec_bit;
        shift_d[cnt_q]   = dec_bit;
        if (cnt_q == CntW'(WORD_W - 1)) begin
          word_d       = shift_d;
          word_valid_d = 1'b1;
          cnt_d        = '0;
          shift_d      = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end else begin
        state_d     = StS0;
        cnt_d       = '0;
        shift_d     = '0;
        err_pulse_d = 1'b1;
        err_flag_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StS0;
      cnt_q        <= '0;
      shift_q      <= '0;
      word_q       <= '0;
      bit_valid_q  <= 1'b0;
      bit_q        <= 1'b0;
      word_valid_q <= 1'b0;
      err_pulse_q  <= 1'b0;
      err_flag_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      word_q       <= word_d;
      bit_valid_q  <= bit_valid_d;
      bit_q        <= bit_d;
      word_valid_q <= word_valid_d;
      err_pulse_q  <= err_pulse_d;
      err_flag_q   <= err_flag_d;
    end
  end

  assign bit_valid_o  = bit_valid_q;
  assign bit_out_o    = bit_q;
  assign word_valid_o = word_valid_q;
  assign word_out_o   = word_q;
  assign err_pulse_o  = err_pulse_q;
  assign err_flag_o   = err_flag_q;

endmodule

// File: tb/tb_mealy_mac_decoder.sv
// Directed bench for mealy_mac_decoder: decode, packing, errors, gaps and reset behaviour.
module tb_mealy_mac_decoder;

  logic       clk;
  logic       reset;
  logic       sym_valid;
  logic [1:0] sym_in;
  logic       clear_err;
  logic       bit_valid;
  logic       bit_out;
  logic       word_valid;
  logic [7:0] word_out;
  logic       err_pulse;
  logic       err_flag;

  int errors = 0;
  int checks = 0;

  // Packing stream 00,00,01x6 decodes to 1,0,1,0,1,0,1,0 -> 0x55.
  logic [1:0] pk_sym [8] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01};
  logic [7:0] pk_bits = 8'h55;
  // Second stream 10,01,01,01,10,11,10,00 decodes to 0,1,0,1,1,1,1,0 -> 0x7A.
  logic [1:0] fr_sym [8] = '{2'b10, 2'b01, 2'b01, 2'b01, 2'b10, 2'b11, 2'b10, 2'b00};
  logic [7:0] fr_bits = 8'h7A;

  mealy_mac_decoder #(.WORD_W(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .sym_valid_i  (sym_valid),
    .sym_in_i     (sym_in),
    .clear_err_i  (clear_err),
    .bit_valid_o  (bit_valid),
    .bit_out_o    (bit_out),
    .word_valid_o (word_valid),
    .word_out_o   (word_out),
    .err_pulse_o  (err_pulse),
    .err_flag_o   (err_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs at the falling edge; return 1 time unit after the rising edge.
  task automatic step(input logic v, input logic [1:0] s, input logic clr);
    @(negedge clk);
    sym_valid = v;
    sym_in    = s;
    clear_err = clr;
    @(posedge clk);
    #1;
  endtask

  // Reset is held for one edge with a valid symbol present; the symbol must be dropped.
  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b1;
    sym_valid = 1'b1;
    sym_in    = 2'b00;
    clear_err = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    reset     = 1'b0;
    sym_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({bit_valid, bit_out, word_valid, err_pulse, err_flag} !== 5'b0) begin
      errors++;
      $display("FAIL reset_pulses: got %b expected 00000",
               {bit_valid, bit_out, word_valid, err_pulse, err_flag});
    end
    checks++;
    if (word_out !== 8'h00) begin
      errors++;
      $display("FAIL reset_word: got %h expected 00", word_out);
    end
  endtask

  task automatic test_basic();
    logic [1:0] syms [4] = '{2'b00, 2'b01, 2'b10, 2'b00};
    logic [3:0] exp = 4'b0111;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, syms[i], 1'b0);
      checks++;
      if ({bit_valid, bit_out, err_pulse} !== {1'b1, exp[i], 1'b0}) begin
        errors++;
        $display("FAIL basic_bit%0d: got v/b/e=%b expected %b", i,
                 {bit_valid, bit_out, err_pulse}, {1'b1, exp[i], 1'b0});
      end
    end
    step(1'b0, 2'b00, 1'b0);
    checks++;
    if ({bit_valid, err_pulse} !== 2'b00) begin
      errors++;
      $display("FAIL basic_idle: got v/e=%b expected 00", {bit_valid, err_pulse});
    end
  endtask

  task automatic test_word();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(1'b1, pk_sym[i], 1'b0);
      checks++;
      if ({bit_valid, bit_out, word_valid} !== {1'b1, pk_bits[i], (i == 7)}) begin
        errors++;
        $display("FAIL word_bit%0d: got v/b/w=%b expected %b", i,
                 {bit_valid, bit_out, word_valid}, {1'b1, pk_bits[i], (i == 7)});
      end
    end
    checks++;
    if (word_out !== 8'h55) begin
      errors++;
      $display("FAIL word_out: got %h expected 55", word_out);
    end
    step(1'b0, 2'b00, 1'b0);
    checks++;
    if (word_valid !== 1'b0 || word_out !== 8'h55) begin
      errors++;
      $display("FAIL word_hold: got w=%b out=%h expected w=0 out=55", word_valid, word_out);
    end
  endtask

  task automatic test_illegal();
    do_reset();
    step(1'b1, 2'b00, 1'b0);
    step(1'b1, 2'b01, 1'b0);
    step(1'b1, 2'b10, 1'b0);
    step(1'b1, 2'b01, 1'b0);  // illegal in S3
    checks++;
    if ({err_pulse, err_flag, bit_valid} !== 3'b110) begin
      errors++;
      $display("FAIL illegal_err: got p/f/v=%b expected 110", {err_pulse, err_flag, bit_valid});
    end
    step(1'b0, 2'b00, 1'b0);
    checks++;
    if ({err_pulse, err_flag} !== 2'b01) begin
      errors++;
      $display("FAIL illegal_pulse_len: got p/f=%b expected 01", {err_pulse, err_flag});
    end
    // Resumes from S0 with an empty partial word.
    for (int i = 0; i < 8; i++) begin
      step(1'b1, pk_sym[i], 1'b0);
      checks++;
      if ({bit_valid, bit_out, word_valid, err_pulse} !==
          {1'b1, pk_bits[i], (i == 7), 1'b0}) begin
        errors++;
        $display("FAIL illegal_resume%0d: got v/b/w/e=%b expected %b", i,
                 {bit_valid, bit_out, word_valid, err_pulse}, {1'b1, pk_bits[i], (i == 7), 1'b0});
      end
    end
    checks++;
    if (word_out !== 8'h55) begin
      errors++;
      $display("FAIL illegal_word: got %h expected 55", word_out);
    end
  endtask

  task automatic test_gaps();
    int gap;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      gap = int'($urandom_range(2, 0));
      for (int g = 0; g < gap; g++) begin
        step(1'b0, 2'b11, 1'b0);
        checks++;
        if ({bit_valid, word_valid, err_pulse} !== 3'b000) begin
          errors++;
          $display("FAIL gap_idle%0d: got v/w/e=%b expected 000", i,
                   {bit_valid, word_valid, err_pulse});
        end
      end
      step(1'b1, pk_sym[i], 1'b0);
      checks++;
      if ({bit_valid, bit_out, word_valid} !== {1'b1, pk_bits[i], (i == 7)}) begin
        errors++;
        $display("FAIL gap_bit%0d: got v/b/w=%b expected %b", i,
                 {bit_valid, bit_out, word_valid}, {1'b1, pk_bits[i], (i == 7)});
      end
    end
    checks++;
    if (word_out !== 8'h55) begin
      errors++;
      $display("FAIL gap_word: got %h expected 55", word_out);
    end
  endtask

  task automatic test_err_flag();
    do_reset();
    step(1'b1, 2'b11, 1'b0);  // illegal in S0
    checks++;
    if ({err_pulse, err_flag} !== 2'b11) begin
      errors++;
      $display("FAIL errf_set: got p/f=%b expected 11", {err_pulse, err_flag});
    end
    step(1'b0, 2'b00, 1'b1);
    checks++;
    if (err_flag !== 1'b0) begin
      errors++;
      $display("FAIL errf_clear: got %b expected 0", err_flag);
    end
    step(1'b1, 2'b01, 1'b1);  // illegal in S0 with clear: set wins
    checks++;
    if ({err_pulse, err_flag} !== 2'b11) begin
      errors++;
      $display("FAIL errf_set_wins: got p/f=%b expected 11", {err_pulse, err_flag});
    end
    step(1'b0, 2'b00, 1'b0);
    checks++;
    if (err_flag !== 1'b1) begin
      errors++;
      $display("FAIL errf_sticky: got %b expected 1", err_flag);
    end
  endtask

  task automatic test_reset_midword();
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b1, pk_sym[i], 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, pk_sym[i], 1'b0);
    do_reset();
    checks++;
    if ({bit_valid, word_valid, err_pulse, err_flag} !== 4'b0 || word_out !== 8'h00) begin
      errors++;
      $display("FAIL midrst_state: got v/w/e/f=%b out=%h expected 0000 out=00",
               {bit_valid, word_valid, err_pulse, err_flag}, word_out);
    end
    for (int i = 0; i < 8; i++) begin
      step(1'b1, fr_sym[i], 1'b0);
      checks++;
      if ({bit_valid, bit_out, word_valid, err_pulse} !==
          {1'b1, fr_bits[i], (i == 7), 1'b0}) begin
        errors++;
        $display("FAIL midrst_bit%0d: got v/b/w/e=%b expected %b", i,
                 {bit_valid, bit_out, word_valid, err_pulse}, {1'b1, fr_bits[i], (i == 7), 1'b0});
      end
    end
    checks++;
    if (word_out !== 8'h7A) begin
      errors++;
      $display("FAIL midrst_word: got %h expected 7a", word_out);
    end
  endtask

  initial begin
    reset     = 1'b1;
    sym_valid = 1'b0;
    sym_in    = 2'b00;
    clear_err = 1'b0;
    repeat (2) @(posedge clk);
    test_reset();
    test_basic();
    test_word();
    test_illegal();
    test_gaps();
    test_err_flag();
    test_reset_midword();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
